// File: rtl/pc_fetch_ctrl_pkg.sv
// rtl/pc_fetch_ctrl_pkg.sv - shared state, next-PC select encodings and reset default for the PC controller
package pc_defs;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [1:0]  PCSRC_PLUS4      = 2'b00;
  localparam logic [1:0]  PCSRC_TARGET     = 2'b01;
  localparam logic [1:0]  PCSRC_JALR       = 2'b10;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC mux with misaligned-target detection
import pc_defs::*;

module pc_next_sel (
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] pc_target_i,
  input  logic [31:0] alu_result_i,
  input  logic [1:0]  pc_src_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  always_comb begin
    next_pc_o = pc_plus4_i;
    case (pc_src_i)
      PCSRC_TARGET: next_pc_o = pc_target_i;
      // JALR drops bit 0 of rs1+imm; bit 1 can still leave the target misaligned
      PCSRC_JALR:   next_pc_o = {alu_result_i[31:1], 1'b0};
      default:      next_pc_o = pc_plus4_i;
    endcase
  end

  assign misaligned_o = |next_pc_o[1:0];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - RV32I PC register, next-PC FSM, retire counter; PC_MISALIGN_TRAP_EN enables target trapping
import pc_defs::*;

module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  input  logic [1:0]  PCSrc,
  input  logic        Stall,
  input  logic        imem_ready,
  input  logic        Halt,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        pc_valid,
  output logic        halted,
  output logic [31:0] InstRet,
  output logic        misalign_trap,
  output logic [31:0] trap_addr
);

  pc_state_e   state_q;
  logic [31:0] pc_q;
  logic [31:0] instret_q;
  logic [31:0] instret_d;
  logic        pc_valid_q;
  logic        halted_q;
  logic [31:0] next_pc;
  logic        next_misaligned;
  logic        advance;

  assign PCPlus4   = pc_q + 32'd4;
  assign instret_d = instret_q + 32'd1;
  assign advance   = imem_ready && !Stall;

  pc_next_sel u_next_sel (
    .pc_plus4_i   (PCPlus4),
    .pc_target_i  (PCTarget),
    .alu_result_i (ALUResult),
    .pc_src_i     (PCSrc),
    .next_pc_o    (next_pc),
    .misaligned_o (next_misaligned)
  );

`ifdef PC_MISALIGN_TRAP_EN
  logic        trap_q;
  logic [31:0] trap_addr_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      instret_q  <= 32'd0;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q      <= 1'b0;
      trap_addr_q <= 32'd0;
`endif
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
        end
        ST_RUN: begin
          if (advance) begin
            // Halt wins over the alignment check: the ECALL/EBREAK itself retires
            if (Halt) begin
              state_q    <= ST_HALT;
              pc_valid_q <= 1'b0;
              halted_q   <= 1'b1;
              instret_q  <= instret_d;
            end else if (next_misaligned) begin
`ifdef PC_MISALIGN_TRAP_EN
              state_q     <= ST_HALT;
              pc_valid_q  <= 1'b0;
              halted_q    <= 1'b1;
              trap_q      <= 1'b1;
              trap_addr_q <= next_pc;
`else
              pc_q      <= {next_pc[31:2], 2'b00};
              instret_q <= instret_d;
`endif
            end else begin
              pc_q      <= next_pc;
              instret_q <= instret_d;
            end
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q    <= ST_BOOT;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign PC       = pc_q;
  assign InstRet  = instret_q;
  assign pc_valid = pc_valid_q;
  assign halted   = halted_q;

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
  assign trap_addr     = trap_addr_q;
`else
  assign misalign_trap = 1'b0;
  assign trap_addr     = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl (RESET_PC=0x100)
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCTarget;
  logic [31:0] ALUResult;
  logic [1:0]  PCSrc;
  logic        Stall;
  logic        imem_ready;
  logic        Halt;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        pc_valid;
  logic        halted;
  logic [31:0] InstRet;
  logic        misalign_trap;
  logic [31:0] trap_addr;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCTarget      (PCTarget),
    .ALUResult     (ALUResult),
    .PCSrc         (PCSrc),
    .Stall         (Stall),
    .imem_ready    (imem_ready),
    .Halt          (Halt),
    .PC            (PC),
    .PCPlus4       (PCPlus4),
    .pc_valid      (pc_valid),
    .halted        (halted),
    .InstRet       (InstRet),
    .misalign_trap (misalign_trap),
    .trap_addr     (trap_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc_e, input logic [31:0] ir_e,
                             input logic pv_e, input logic h_e);
    check({tag, "_pc"}, PC, pc_e);
    check({tag, "_instret"}, InstRet, ir_e);
    check({tag, "_pc_valid"}, {31'd0, pc_valid}, {31'd0, pv_e});
    check({tag, "_halted"}, {31'd0, halted}, {31'd0, h_e});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b0; PCTarget = 32'd0; ALUResult = 32'd0; PCSrc = 2'b00;
    Stall = 1'b0; imem_ready = 1'b1; Halt = 1'b0;
    @(negedge clk);
    do_reset();
    check_state("reset", 32'h100, 32'd0, 1'b0, 1'b0);
    check("reset_trap", {31'd0, misalign_trap}, 32'd0);
    check("reset_trap_addr", trap_addr, 32'd0);

    rst_n = 1'b1;
    check_state("boot", 32'h100, 32'd0, 1'b0, 1'b0);
    step();
    check_state("run0", 32'h100, 32'd0, 1'b1, 1'b0);
    check("pcplus4_0", PCPlus4, 32'h104);
    step();
    check_state("run1", 32'h104, 32'd1, 1'b1, 1'b0);
    step();
    check_state("run2", 32'h108, 32'd2, 1'b1, 1'b0);
    step();
    check_state("run3", 32'h10C, 32'd3, 1'b1, 1'b0);

    PCSrc = 2'b01; PCTarget = 32'h200;
    step();
    check_state("jmp200", 32'h200, 32'd4, 1'b1, 1'b0);
    PCTarget = 32'h40;
    step();
    check_state("br40", 32'h40, 32'd5, 1'b1, 1'b0);
    PCSrc = 2'b10; ALUResult = 32'h81;
    step();
    check_state("jalr80", 32'h80, 32'd6, 1'b1, 1'b0);
    PCSrc = 2'b11;
    step();
    check_state("rsvd84", 32'h84, 32'd7, 1'b1, 1'b0);
    PCSrc = 2'b01; PCTarget = 32'h10;
    step();
    check_state("jmp10", 32'h10, 32'd8, 1'b1, 1'b0);

    PCTarget = 32'h999; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("stall", 32'h10, 32'd8, 1'b1, 1'b0);
    end
    Stall = 1'b0; imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_state("notready", 32'h10, 32'd8, 1'b1, 1'b0);
    end
    imem_ready = 1'b1; PCSrc = 2'b00;
    step();
    check_state("resume", 32'h14, 32'd9, 1'b1, 1'b0);

    Stall = 1'b1;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    check("ir_preload", InstRet, 32'hFFFF_FFFF);
    Stall = 1'b0; PCSrc = 2'b01; PCTarget = 32'hFFFF_FFFC;
    step();
    check_state("ir_wrap", 32'hFFFF_FFFC, 32'd0, 1'b1, 1'b0);
    check("pcplus4_wrap", PCPlus4, 32'h0);
    PCSrc = 2'b00;
    step();
    check_state("pc_wrap", 32'h0, 32'd1, 1'b1, 1'b0);

    PCSrc = 2'b01; PCTarget = 32'h30;
    step();
    check_state("jmp30", 32'h30, 32'd2, 1'b1, 1'b0);
    Halt = 1'b1; PCSrc = 2'b01; PCTarget = 32'h500;
    step();
    check_state("halt", 32'h30, 32'd3, 1'b0, 1'b1);
    Halt = 1'b0; PCTarget = 32'h600;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("halt_hold", 32'h30, 32'd3, 1'b0, 1'b1);
      PCSrc = PCSrc + 2'b01;
    end
    do_reset();
    check_state("halt_reset", 32'h100, 32'd0, 1'b0, 1'b0);

    PCSrc = 2'b00;
    rst_n = 1'b1;
    step();
    check_state("reboot", 32'h100, 32'd0, 1'b1, 1'b0);
    PCSrc = 2'b01; PCTarget = 32'h102;
    step();
`ifdef PC_MISALIGN_TRAP_EN
    check_state("trap", 32'h100, 32'd0, 1'b0, 1'b1);
    check("trap_flag", {31'd0, misalign_trap}, 32'd1);
    check("trap_addr", trap_addr, 32'h102);
    PCTarget = 32'h200;
    step();
    check_state("trap_hold", 32'h100, 32'd0, 1'b0, 1'b1);
    do_reset();
    check("trap_clr", {31'd0, misalign_trap}, 32'd0);
    check("trap_addr_clr", trap_addr, 32'd0);
`else
    check_state("misalign", 32'h100, 32'd1, 1'b1, 1'b0);
    check("no_trap", {31'd0, misalign_trap}, 32'd0);
    check("no_trap_addr", trap_addr, 32'd0);
    PCSrc = 2'b10; ALUResult = 32'h0000_0203;
    step();
    check_state("jalr_misalign", 32'h200, 32'd2, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
